// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared sizing constants and state type for the cluster readout scheduler
package cluster_pkg;

    localparam int MXPAD   = 64;
    localparam int MXCLUST = 8;
    localparam int CNT_W   = 3;
    localparam int ADR_W   = $clog2(MXPAD);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/pad_prio_enc.sv
// rtl/pad_prio_enc.sv - combinational lowest-set-bit finder returning index and mask with that bit cleared
module pad_prio_enc #(
    parameter int MXPAD = cluster_pkg::MXPAD
) (
    input  logic [MXPAD-1:0]         mask_in,
    output logic                     found,
    output logic [$clog2(MXPAD)-1:0] idx,
    output logic [MXPAD-1:0]         mask_out
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        for (int i = MXPAD - 1; i >= 0; i--) begin
            if (mask_in[i]) begin
                found = 1'b1;
                idx   = i[$clog2(MXPAD)-1:0];
            end
        end
        mask_out = mask_in;
        if (found) begin
            mask_out[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/cluster_readout_sched.sv
// rtl/cluster_readout_sched.sv - serialises a frame of pad seeds into valid/ready cluster words; CLUSTER_SCHED_DROP_CNT_EN enables the dropped-frame counter
module cluster_readout_sched #(
    parameter int MXPAD   = cluster_pkg::MXPAD,
    parameter int MXCLUST = cluster_pkg::MXCLUST
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_valid,
    input  logic [MXPAD-1:0]         vpf,
    input  logic [3*MXPAD-1:0]       cnt,
    output logic                     clust_valid,
    input  logic                     clust_ready,
    output logic [$clog2(MXPAD)-1:0] clust_adr,
    output logic [2:0]               clust_cnt,
    output logic                     clust_last,
    output logic                     busy,
    output logic                     overflow,
    output logic                     frame_drop,
    output logic [15:0]              drop_cnt
);

    import cluster_pkg::*;

    localparam int AW = $clog2(MXPAD);
    localparam int EW = $clog2(MXCLUST + 1);
    localparam logic [EW-1:0] LAST_EMIT = EW'(MXCLUST - 1);

    state_t               state_q, state_d;
    logic [MXPAD-1:0]     mask_q, mask_d;
    logic [CNT_W*MXPAD-1:0] shadow_q, shadow_d;
    logic [EW-1:0]        emitted_q, emitted_d;

    logic                 enc_found;
    logic [AW-1:0]        enc_idx;
    logic [MXPAD-1:0]     enc_rest;
    logic                 handshake;

    pad_prio_enc #(.MXPAD(MXPAD)) u_prio (
        .mask_in  (mask_q),
        .found    (enc_found),
        .idx      (enc_idx),
        .mask_out (enc_rest)
    );

    // Output word is a pure function of the registers, so it holds still under backpressure.
    always_comb begin
        busy        = (state_q == SCAN);
        clust_valid = busy && enc_found;
        clust_adr   = clust_valid ? enc_idx : '0;
        clust_cnt   = clust_valid ? shadow_q[enc_idx*CNT_W +: CNT_W] : '0;
        clust_last  = clust_valid && ((enc_rest == '0) || (emitted_q == LAST_EMIT));
        handshake   = clust_valid && clust_ready;
        overflow    = handshake && (emitted_q == LAST_EMIT) && (enc_rest != '0);
        frame_drop  = frame_valid && busy;
    end

    // Frame load in IDLE, one bit retired per handshake in SCAN; leftover bits are discarded at the end.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        emitted_d = emitted_q;
        case (state_q)
            IDLE: begin
                if (frame_valid && (vpf != '0)) begin
                    mask_d    = vpf;
                    shadow_d  = cnt;
                    emitted_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (handshake) begin
                    emitted_d = emitted_q + EW'(1);
                    mask_d    = enc_rest;
                    if (clust_last) begin
                        mask_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, mask, shadow counts and emitted counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            shadow_q  <= '0;
            emitted_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            emitted_q <= emitted_d;
        end
    end

`ifdef CLUSTER_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of frames rejected while busy.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (frame_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Dropped-frame counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cluster_readout_sched.sv
// tb/tb_cluster_readout_sched.sv - directed scoreboard bench for cluster_readout_sched
module tb_cluster_readout_sched;

    localparam int MXPAD   = 64;
    localparam int MXCLUST = 8;

    logic                clock;
    logic                reset_n;
    logic                frame_valid;
    logic [MXPAD-1:0]    vpf;
    logic [3*MXPAD-1:0]  cnt;
    logic                clust_valid;
    logic                clust_ready;
    logic [5:0]          clust_adr;
    logic [2:0]          clust_cnt;
    logic                clust_last;
    logic                busy;
    logic                overflow;
    logic                frame_drop;
    logic [15:0]         drop_cnt;

    typedef struct {
        logic [5:0] adr;
        logic [2:0] cnt;
        logic       last;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   drops_seen;
    int   ovf_seen;
    int   valid_cycles;
    int   snap;

    cluster_readout_sched #(.MXPAD(MXPAD), .MXCLUST(MXCLUST)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .vpf         (vpf),
        .cnt         (cnt),
        .clust_valid (clust_valid),
        .clust_ready (clust_ready),
        .clust_adr   (clust_adr),
        .clust_cnt   (clust_cnt),
        .clust_last  (clust_last),
        .busy        (busy),
        .overflow    (overflow),
        .frame_drop  (frame_drop),
        .drop_cnt    (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected readout of a frame: ascending set bits, capped at MXCLUST words.
    task automatic push_frame(input logic [MXPAD-1:0] v, input logic [3*MXPAD-1:0] c);
        int   n;
        int   remaining;
        exp_t e;
        n = 0;
        remaining = $countones(v);
        for (int i = 0; i < MXPAD; i++) begin
            if (v[i] && n < MXCLUST) begin
                e.adr  = 6'(i);
                e.cnt  = c[3*i +: 3];
                n++;
                remaining--;
                e.last = (remaining == 0) || (n == MXCLUST);
                e.ovf  = (n == MXCLUST) && (remaining != 0);
                sb.push_back(e);
            end
        end
    endtask

    // One clock: sample mid-cycle, score any handshake, then advance to 1 unit past the next edge.
    task automatic cycle();
        exp_t e;
        #3;
        if (frame_drop === 1'b1) drops_seen++;
        if (overflow === 1'b1) ovf_seen++;
        if (clust_valid === 1'b1) valid_cycles++;
        if (clust_valid === 1'b1 && clust_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("word_adr", 32'(clust_adr), 32'(e.adr));
                check("word_cnt", 32'(clust_cnt), 32'(e.cnt));
                check("word_last", 32'(clust_last), 32'(e.last));
                check("word_ovf", 32'(overflow), 32'(e.ovf));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [MXPAD-1:0] v, input logic [3*MXPAD-1:0] c, input bit accept);
        vpf         = v;
        cnt         = c;
        frame_valid = 1'b1;
        if (accept) push_frame(v, c);
        cycle();
        frame_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [MXPAD-1:0]   v;
        logic [3*MXPAD-1:0] c;
        logic [15:0]        exp_drop1;
        logic [15:0]        exp_drop2;

        total = 0; bad = 0; drops_seen = 0; ovf_seen = 0; valid_cycles = 0;
        reset_n = 1'b0; frame_valid = 1'b0; vpf = '0; cnt = '0; clust_ready = 1'b1;

`ifdef CLUSTER_SCHED_DROP_CNT_EN
        exp_drop1 = 16'd1; exp_drop2 = 16'd2;
`else
        exp_drop1 = 16'd0; exp_drop2 = 16'd0;
`endif

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(clust_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_adr", 32'(clust_adr), 32'd0);
        check("rst_last", 32'(clust_last), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
        cycle();

        // three seeds, full throughput
        v = '0; c = '0;
        v[3] = 1'b1; v[10] = 1'b1; v[40] = 1'b1;
        c[9 +: 3] = 3'd2; c[30 +: 3] = 3'd0; c[120 +: 3] = 3'd7;
        strobe(v, c, 1'b1);
        check("t1_latency_valid", 32'(clust_valid), 32'd1);
        repeat (3) cycle();
        check("t1_empty_after_3", 32'(sb.size()), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // sixteen seeds, capped at MXCLUST with overflow
        v = '0; c = '0;
        v[15:0] = 16'hFFFF;
        for (int i = 0; i < 16; i++) c[3*i +: 3] = 3'(i % 8);
        strobe(v, c, 1'b1);
        drain(20);
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_ovf_count", 32'(ovf_seen), 32'd1);
        snap = valid_cycles;
        repeat (2) cycle();
        check("t2_discarded", 32'(valid_cycles - snap), 32'd0);

        // single top seed under backpressure
        v = '0; c = '0;
        v[63] = 1'b1; c[189 +: 3] = 3'd5;
        clust_ready = 1'b0;
        strobe(v, c, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", 32'(clust_valid), 32'd1);
            check("t3_hold_adr", 32'(clust_adr), 32'd63);
            check("t3_hold_cnt", 32'(clust_cnt), 32'd5);
            check("t3_hold_last", 32'(clust_last), 32'd1);
            cycle();
        end
        clust_ready = 1'b1;
        cycle();
        check("t3_empty", 32'(sb.size()), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);

        // frame arriving mid-frame is dropped
        v = '0; c = '0;
        v[1] = 1'b1; v[5] = 1'b1; v[9] = 1'b1;
        c[3 +: 3] = 3'd4; c[15 +: 3] = 3'd3; c[27 +: 3] = 3'd6;
        strobe(v, c, 1'b1);
        cycle();
        vpf = 64'hF0; frame_valid = 1'b1;
        cycle();
        frame_valid = 1'b0;
        check("t4_drop_pulses", 32'(drops_seen), 32'd1);
        check("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drop1));
        cycle();
        check("t4_empty", 32'(sb.size()), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // frame arriving on the final handshake cycle is also dropped
        v = '0; c = '0;
        v[2] = 1'b1; v[3] = 1'b1; c[6 +: 3] = 3'd1; c[9 +: 3] = 3'd2;
        strobe(v, c, 1'b1);
        cycle();
        vpf = 64'h3; frame_valid = 1'b1;
        cycle();
        frame_valid = 1'b0;
        check("t5_drop_pulses", 32'(drops_seen), 32'd2);
        check("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drop2));
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_empty", 32'(sb.size()), 32'd0);

        // asynchronous reset during the second word of a five-word frame
        v = '0; c = '0;
        v[4:0] = 5'h1F;
        for (int i = 0; i < 5; i++) c[3*i +: 3] = 3'(i + 1);
        strobe(v, c, 1'b1);
        cycle();
        check("t6_second_adr", 32'(clust_adr), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(clust_valid), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_adr", 32'(clust_adr), 32'd0);
        check("t6_async_cnt", 32'(clust_cnt), 32'd0);
        check("t6_async_last", 32'(clust_last), 32'd0);
        check("t6_async_drop_cnt", 32'(drop_cnt), 32'd0);
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        snap = valid_cycles;
        repeat (4) cycle();
        check("t6_quiet_after_reset", 32'(valid_cycles - snap), 32'd0);

        // empty frame is ignored
        snap = valid_cycles;
        strobe('0, '0, 1'b0);
        check("t7_busy", 32'(busy), 32'd0);
        repeat (3) cycle();
        check("t7_no_valid", 32'(valid_cycles - snap), 32'd0);
        check("t7_no_drop", 32'(drops_seen), 32'd2);
        check("t7_no_ovf", 32'(ovf_seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cluster_readout_sched.md
CLUSTER_READOUT_SCHED -- requirements
Module: cluster_readout_sched

Interface
REQ-001 Parameter MXPAD, default 64, number of pad candidate flags per partition scanned by this block.
REQ-002 Parameter MXCLUST, default 8, maximum clusters read out per frame.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 frame_valid  in  1  one-cycle strobe: vpf/cnt hold a new frame.
REQ-006 vpf  in  MXPAD  valid-pad flags, bit i = cluster seed at pad i.
REQ-007 cnt  in  3*MXPAD  per-pad 3-bit consecutive count, pad i at bits [3i+2:3i].
REQ-008 clust_valid  out  1  output cluster word valid.
REQ-009 clust_ready  in  1  downstream accepts word when high with clust_valid.
REQ-010 clust_adr  out  clog2(MXPAD)  pad address of presented cluster.
REQ-011 clust_cnt  out  3  count of presented cluster.
REQ-012 clust_last  out  1  presented word is final word of frame.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 overflow  out  1  one-cycle pulse: frame held more than MXCLUST clusters.
REQ-015 frame_drop  out  1  one-cycle pulse: frame_valid arrived while busy.
REQ-016 drop_cnt  out  16  dropped-frame counter (see Configuration).

Function
REQ-017 States IDLE, SCAN; IDLE->SCAN on frame_valid with vpf nonzero; SCAN->IDLE on handshake of word with clust_last=1.
REQ-018 In IDLE, frame_valid latches vpf into mask register and cnt into shadow register; frame_valid with vpf==0 stays IDLE, no output, no pulse.
REQ-019 clust_valid rises the cycle after accepted frame_valid (latency 1).
REQ-020 Presented word is always the lowest-indexed set bit of mask, with its shadow count.
REQ-021 Handshake (clust_valid & clust_ready) clears that mask bit and increments the emitted counter; next word valid the following cycle, sustaining one word per cycle while clust_ready held high.
REQ-022 clust_valid, clust_adr, clust_cnt, clust_last held stable while clust_valid=1 and clust_ready=0.
REQ-023 clust_last=1 when presented bit is the only bit left in mask, or emitted count equals MXCLUST-1.
REQ-024 overflow pulses on the handshake of the MXCLUST-th word when mask still holds other bits; remaining bits discarded.
REQ-025 frame_valid during SCAN (including the cycle of the last handshake) is dropped; frame_drop pulses that cycle; in-flight frame unaffected.
REQ-026 Emitted counter width clog2(MXCLUST+1); cleared on every frame load.

Reset
REQ-027 reset_n low: state=IDLE, mask=0, shadow=0, emitted=0, clust_valid=0, clust_adr=0, clust_cnt=0, clust_last=0, busy=0, overflow=0, frame_drop=0, drop_cnt=0.
REQ-028 Reset mid-SCAN abandons the frame immediately; no word emitted after reset release until a new frame_valid.

Configuration
REQ-029 Macro CLUSTER_SCHED_DROP_CNT_EN defined: drop_cnt increments on every frame_drop pulse, saturating at 0xFFFF.
REQ-030 Macro undefined: drop_cnt is constant 0 and no counter flops exist; frame_drop pulse unaffected.

Structure
REQ-031 Shared package cluster_pkg holds MXPAD, MXCLUST, CNT_W=3, ADR_W, and the IDLE/SCAN state type.
REQ-032 Lowest-set-bit search is sub-module pad_prio_enc (MXPAD-bit mask in; found flag, index, and one-hot-cleared mask out), purely combinational.

Verification
REQ-033 vpf bits 3,10,40, cnt 2,0,7, ready=1 -> three words (3,2),(10,0),(40,7) on consecutive cycles starting 1 cycle after strobe, last on adr 40, then busy=0.
REQ-034 vpf=0xFFFF (16 bits), MXCLUST=8 -> words adr 0..7, last on adr 7, overflow pulse with that handshake, then IDLE.
REQ-035 Single bit vpf[63], ready low 5 cycles -> word (63,cnt) held stable 5 cycles with last=1, accepted on cycle 6.
REQ-036 Second frame_valid 2 cycles into a 3-word frame -> frame_drop pulse, original 3 words unchanged; with macro drop_cnt=1, without drop_cnt=0.
REQ-037 reset_n low during 2nd word of a 5-word frame -> all outputs 0 asynchronously; after release, no output until next frame_valid.
REQ-038 frame_valid with vpf=0 -> no clust_valid, busy stays 0, no pulses.
